// File: rtl/spi_rx.sv
// SPI receive datapath: samples sdi on controller sample strobes and packs bits into 32-bit words.
// Define SPI_RX_LSB_FIRST_EN to receive LSB first; the default build receives MSB first.
module spi_rx #(
  parameter int LEN_W  = 16,
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              rx_edge_i,
  input  logic              sdi,
  input  logic [LEN_W-1:0]  rx_bits_len_i,
  input  logic              rx_bits_len_update_i,
  output logic [WORD_W-1:0] rx_data_o,
  output logic [5:0]        rx_data_bits_o,
  output logic              rx_data_vld_o,
  input  logic              rx_data_rdy_i,
  output logic              rx_done_o,
  output logic              rx_busy_o,
  output logic              rx_overflow_o
);

  typedef enum logic {IDLE, RECEIVE} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    work_len_q, work_len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  // The 32nd bit of a word always comes straight from sdi, so 31 stored bits suffice.
  logic [WORD_W-2:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [5:0]          bits_q, bits_d;
  logic                vld_q, vld_d;
  logic                ovf_q, ovf_d;

  logic                sample;
  logic                last_bit;
  logic                word_done;
  logic [WORD_W-1:0]   sample_word;

`ifdef SPI_RX_LSB_FIRST_EN
  logic [WORD_W-1:0]   ins_mask;

  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_ins
    assign ins_mask[gi] = sdi & (cnt_q[4:0] == 5'(gi));
  end

  assign sample_word = {1'b0, shift_q} | ins_mask;
`else
  assign sample_word = {shift_q, sdi};
`endif

  assign sample    = (state_q == RECEIVE) && en_i && rx_edge_i;
  assign last_bit  = (cnt_q + LEN_W'(1)) == work_len_q;
  assign word_done = sample && ((cnt_q[4:0] == 5'd31) || last_bit);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    work_len_d = work_len_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    bits_d     = bits_q;
    vld_d      = vld_q;
    ovf_d      = ovf_q;

    if (vld_q && rx_data_rdy_i) vld_d = 1'b0;
    if (rx_bits_len_update_i)   len_d = rx_bits_len_i;

    case (state_q)
      IDLE: begin
        if (en_i && (len_q != '0)) begin
          state_d    = RECEIVE;
          work_len_d = len_q;
          cnt_d      = '0;
          shift_d    = '0;
          ovf_d      = 1'b0;
        end
      end
      RECEIVE: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (rx_edge_i) begin
          cnt_d   = cnt_q + LEN_W'(1);
          // Clearing at each word boundary keeps the upper bits of a partial word zero.
          shift_d = word_done ? '0 : sample_word[WORD_W-2:0];
          if (word_done) begin
            if (!vld_q || rx_data_rdy_i) begin
              data_d = sample_word;
              bits_d = {1'b0, cnt_q[4:0]} + 6'd1;
              vld_d  = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (last_bit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      work_len_q <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      bits_q     <= '0;
      vld_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      work_len_q <= work_len_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      bits_q     <= bits_d;
      vld_q      <= vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rx_data_o      = data_q;
  assign rx_data_bits_o = bits_q;
  assign rx_data_vld_o  = vld_q;
  assign rx_done_o      = sample && last_bit;
  assign rx_busy_o      = (state_q == RECEIVE);
  assign rx_overflow_o  = ovf_q;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: directed vector table, hand-written corner sequences and a random run
// checked every cycle against a bit-queue reference model.
module tb_spi_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rx_edge;
  logic        sdi;
  logic [15:0] len_in;
  logic        upd;
  logic        rdy;
  logic [31:0] rx_data;
  logic [5:0]  rx_bits;
  logic        rx_vld;
  logic        rx_done;
  logic        rx_busy;
  logic        rx_ovf;

  spi_rx #(.LEN_W(16), .WORD_W(32)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .en_i                 (en),
    .rx_edge_i            (rx_edge),
    .sdi                  (sdi),
    .rx_bits_len_i        (len_in),
    .rx_bits_len_update_i (upd),
    .rx_data_o            (rx_data),
    .rx_data_bits_o       (rx_bits),
    .rx_data_vld_o        (rx_vld),
    .rx_data_rdy_i        (rdy),
    .rx_done_o            (rx_done),
    .rx_busy_o            (rx_busy),
    .rx_overflow_o        (rx_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails_printed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else begin
      if (fails_printed < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      fails_printed++;
    end
  endtask

  // Reference model: bits collected in a queue, words composed only when complete.
  bit          m_busy;
  int          m_len_reg, m_work, m_cnt;
  bit          m_cur[$];
  bit          m_vld;
  logic [31:0] m_data;
  int          m_bits;
  bit          m_ovf;
  logic [31:0] got_d[$];
  int          got_b[$];
  int          done_cnt;
  bit          busy_seen;

  function automatic logic [31:0] compose(input bit q[$]);
    logic [31:0] w = '0;
    for (int i = 0; i < q.size(); i++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      w[i] = q[i];
`else
      w = {w[30:0], q[i]};
`endif
    end
    return w;
  endfunction

  always @(negedge clk) begin
    bit exp_done;
    logic [31:0] w;
    if (rst) begin
      m_busy = 0; m_len_reg = 0; m_work = 0; m_cnt = 0; m_cur.delete();
      m_vld = 0; m_data = '0; m_bits = 0; m_ovf = 0;
    end else begin
      exp_done = m_busy && en && rx_edge && (m_cnt + 1 == m_work);
      check("vld", rx_vld, m_vld);
      if (m_vld) begin
        check("data", rx_data, m_data);
        check("bits", rx_bits, m_bits);
      end
      check("busy", rx_busy, m_busy);
      check("done", rx_done, exp_done);
      check("ovf", rx_ovf, m_ovf);
      if (rx_done) done_cnt++;
      if (rx_busy) busy_seen = 1;
      if (rx_vld && rdy) begin
        got_d.push_back(rx_data);
        got_b.push_back(int'(rx_bits));
      end
      if (m_vld && rdy) m_vld = 0;
      if (!m_busy) begin
        if (en && m_len_reg != 0) begin
          m_busy = 1; m_work = m_len_reg; m_cnt = 0; m_cur.delete(); m_ovf = 0;
        end
      end else if (!en) begin
        m_busy = 0;
        m_cur.delete();
      end else if (rx_edge) begin
        m_cur.push_back(sdi);
        m_cnt++;
        if (m_cur.size() == 32 || m_cnt == m_work) begin
          w = compose(m_cur);
          if (!m_vld) begin
            m_vld = 1; m_data = w; m_bits = m_cur.size();
          end else begin
            m_ovf = 1;
          end
          m_cur.delete();
          if (m_cnt == m_work) m_busy = 0;
        end
      end
      if (upd) m_len_reg = int'(len_in);
    end
  end

  task automatic drive(input bit e, input bit ed, input bit s, input bit r, input bit u, input int l);
    @(posedge clk);
    #2;
    en = e; rx_edge = ed; sdi = s; rdy = r; upd = u; len_in = l[15:0];
  endtask

  task automatic clear_obs();
    got_d.delete(); got_b.delete(); done_cnt = 0; busy_seen = 0;
  endtask

  // words = {w0, w1, w2}; each word is serialised in the build's bit order.
  task automatic run_xfer(input int len, input logic [95:0] words, input int rdy_hold, input int abort_after);
    logic [31:0] w;
    int wi, pos, n, idx;
    clear_obs();
    drive(0, 0, 0, rdy_hold == 0, 1, len);
    drive(1, 0, 0, rdy_hold == 0, 0, 0);
    for (int k = 0; k < len; k++) begin
      if (k == abort_after) break;
      wi  = k / 32;
      pos = k % 32;
      n   = (wi < len / 32) ? 32 : len % 32;
      w   = words[95 - 32*wi -: 32];
`ifdef SPI_RX_LSB_FIRST_EN
      idx = pos;
`else
      idx = n - 1 - pos;
`endif
      if (k > 0) drive(1, 0, 0, k >= rdy_hold, 0, 0);
      drive(1, 1, w[idx], k >= rdy_hold, 0, 0);
    end
    repeat (6) drive(0, 0, 0, 1, 0, 0);
  endtask

  typedef struct {
    int          len;
    logic [95:0] words;
    int          rdy_hold;
    int          exp_n;
    logic [95:0] exp_w;
    logic [17:0] exp_b;
    int          exp_done;
    bit          exp_ovf;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rdy_phase;
    vt[0] = '{32, {32'hA5C30F96, 64'h0}, 0, 1, {32'hA5C30F96, 64'h0}, {6'd32, 12'd0}, 1, 1'b0};
    vt[1] = '{40, {32'hDEADBEEF, 32'h5A, 32'h0}, 0, 2, {32'hDEADBEEF, 32'h5A, 32'h0}, {6'd32, 6'd8, 6'd0}, 1, 1'b0};
    vt[2] = '{96, {32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D}, 70, 2,
              {32'h01234567, 32'hCAFEF00D, 32'h0}, {6'd32, 6'd32, 6'd0}, 1, 1'b1};
    vt[3] = '{1, {32'h1, 64'h0}, 0, 1, {32'h1, 64'h0}, {6'd1, 12'd0}, 1, 1'b0};
    vt[4] = '{33, {32'hFFFFFFFF, 32'h1, 32'h0}, 0, 2, {32'hFFFFFFFF, 32'h1, 32'h0}, {6'd32, 6'd1, 6'd0}, 1, 1'b0};

    rst = 1; en = 0; rx_edge = 0; sdi = 0; rdy = 0; upd = 0; len_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {rx_data, rx_bits, rx_vld, rx_done, rx_busy, rx_ovf}, '0);
    #1;
    rst = 0;

    foreach (vt[v]) begin
      run_xfer(vt[v].len, vt[v].words, vt[v].rdy_hold, -1);
      $display("vector %0d len=%0d words=%0d done=%0d ovf=%0b", v, vt[v].len, got_d.size(), done_cnt, rx_ovf);
      check("n_words", got_d.size(), vt[v].exp_n);
      for (int i = 0; i < vt[v].exp_n && i < got_d.size(); i++) begin
        check("word", got_d[i], vt[v].exp_w[95 - 32*i -: 32]);
        check("word_bits", got_b[i], vt[v].exp_b[17 - 6*i -: 6]);
      end
      check("done_count", done_cnt, vt[v].exp_done);
      check("ovf_sticky", rx_ovf, vt[v].exp_ovf);
      check("busy_after", rx_busy, 0);
    end

    run_xfer(32, {32'hFFFF0000, 64'h0}, 0, 10);
    $display("abort: words=%0d done=%0d busy=%0b", got_d.size(), done_cnt, rx_busy);
    check("abort_no_word", got_d.size(), 0);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", rx_busy, 0);
    run_xfer(32, {32'h12345678, 64'h0}, 0, -1);
    $display("after abort: words=%0d", got_d.size());
    check("after_abort_n", got_d.size(), 1);
    if (got_d.size() > 0) check("after_abort_word", got_d[0], 32'h12345678);

    clear_obs();
    drive(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, i % 2, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    $display("len0: busy_seen=%0b done=%0d words=%0d", busy_seen, done_cnt, got_d.size());
    check("len0_busy", busy_seen, 0);
    check("len0_done", done_cnt, 0);
    check("len0_words", got_d.size(), 0);

    drive(0, 0, 0, 0, 1, 40);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 34; k++) begin
      drive(1, 1, k[0], 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    check("pre_reset_busy", rx_busy, 1);
    check("pre_reset_vld", rx_vld, 1);
    #1;
    rx_edge = 1; rst = 1;
    #1;
    $display("async reset: data=%h vld=%0b busy=%0b", rx_data, rx_vld, rx_busy);
    check("arst_data", rx_data, 0);
    check("arst_ctrl", {rx_bits, rx_vld, rx_done, rx_busy, rx_ovf}, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 0;

    clear_obs();
    rdy_phase = 1;
    drive(0, 0, 0, 1, 1, 20);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom % 80 == 0) rdy_phase = !rdy_phase;
      drive(($urandom % 150) != 0, $urandom % 2, $urandom % 2,
            rdy_phase ? (($urandom % 4) != 0) : 1'b0,
            ($urandom % 40) == 0,
            ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 100)));
    end
    $display("random: words=%0d done=%0d", got_d.size(), done_cnt);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
